// File: rtl/census_window_3x11_if.sv
// Pixel-in / census-out bundle for census_window_3x11.
// The producer of pixels (and consumer of signatures) uses master; the transform uses slave.
interface census_window_3x11_if;
    logic        en;
    logic [7:0]  inData;
    logic [9:0]  row_in;
    logic [9:0]  col_in;
    logic [31:0] outData;
    logic [9:0]  row_out;
    logic [9:0]  col_out;
    logic        valid;
    logic [19:0] test_cnt;

    modport master (
        output en, inData, row_in, col_in,
        input  outData, row_out, col_out, valid, test_cnt
    );

    modport slave (
        input  en, inData, row_in, col_in,
        output outData, row_out, col_out, valid, test_cnt
    );
endinterface

// File: rtl/census_window_3x11.sv
// Streaming 3x11 census transform: one 32-bit signature per accepted 8-bit pixel,
// centred IMG_COLS+5 pixels behind the input in raster order.
module census_window_3x11 #(
    parameter int IMG_ROWS = 200,
    parameter int IMG_COLS = 400
) (
    input  logic                 clk,
    input  logic                 rst_n,
    census_window_3x11_if.slave  bus
);
    localparam int TAPS = 11;
    localparam int CTR  = 5;
    localparam int WARM = IMG_COLS + 5;
    localparam int AW   = $clog2(IMG_COLS);

    logic [7:0]    line1 [IMG_COLS];
    logic [7:0]    line2 [IMG_COLS];
    logic [7:0]    sr    [3][TAPS-1];
    logic [7:0]    win   [3][TAPS];
    logic [AW-1:0] addr;
    logic [7:0]    centre;
    logic [31:0]   census;
    logic [9:0]    c_row;
    logic [9:0]    c_col;
    logic          border;
    logic [10:0]   warm_cnt;
    logic          warm_done;

    logic [31:0]   out_data_q;
    logic [9:0]    row_q;
    logic [9:0]    col_q;
    logic          valid_q;
    logic [19:0]   cnt_q;

    assign addr      = bus.col_in[AW-1:0];
    assign warm_done = (warm_cnt == 11'(WARM));

    // NOTE: line buffers carry no reset; stale contents are hidden by warm-up and border zeroing.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            line1[addr] <= bus.inData;
            line2[addr] <= line1[addr];
        end
    end

    // Tap 0 of each window row is the live value about to be shifted in.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k < TAPS; k++) begin
                win[r][k] = sr[r][k-1];
            end
        end
        win[0][0] = line2[addr];
        win[1][0] = line1[addr];
        win[2][0] = bus.inData;
    end

    assign centre = win[1][CTR];

    // Higher tap index is further left, so walking k downwards is raster order.
    always_comb begin
        census = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = TAPS - 1; k >= 0; k--) begin
                if (!(r == 1 && k == CTR)) begin
                    census = {census[30:0], (win[r][k] < centre)};
                end
            end
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        c_row = '0;
        c_col = '0;
        if (bus.col_in >= 10'd5) begin
            c_col = bus.col_in - 10'd5;
            c_row = (bus.row_in >= 10'd1) ? bus.row_in - 10'd1
                                          : bus.row_in + 10'(IMG_ROWS - 1);
        end else begin
            c_col = bus.col_in + 10'(IMG_COLS - 5);
            c_row = (bus.row_in >= 10'd2) ? bus.row_in - 10'd2
                                          : bus.row_in + 10'(IMG_ROWS - 2);
        end
        border = (c_row == 10'd0) || (c_row == 10'(IMG_ROWS - 1)) ||
                 (c_col < 10'd5)  || (c_col > 10'(IMG_COLS - 6));
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < TAPS - 1; k++) begin
                    sr[r][k] <= '0;
                end
            end
            warm_cnt   <= '0;
            out_data_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.en) begin
                cnt_q <= cnt_q + 20'd1;
                for (int r = 0; r < 3; r++) begin
                    for (int k = 0; k < TAPS - 1; k++) begin
                        sr[r][k] <= win[r][k];
                    end
                end
                if (!warm_done) begin
                    warm_cnt <= warm_cnt + 11'd1;
                end else begin
                    valid_q    <= 1'b1;
                    out_data_q <= border ? 32'd0 : census;
                    row_q      <= c_row;
                    col_q      <= c_col;
                end
            end
        end
    end

    assign bus.outData  = out_data_q;
    assign bus.row_out  = row_q;
    assign bus.col_out  = col_q;
    assign bus.valid    = valid_q;
    assign bus.test_cnt = cnt_q;
endmodule

// File: tb/tb_census_window_3x11.sv
// Scoreboard bench for census_window_3x11: a raster-history model predicts every output,
// plus directed checks of warm-up, borders, frame counts and mid-stream reset.
module tb_census_window_3x11;
    localparam int R    = 12;
    localparam int C    = 400;
    localparam int WARM = C + 5;

    typedef struct {
        logic [31:0] data;
        bit          known;
        logic [9:0]  row;
        logic [9:0]  col;
        int          fid;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    census_window_3x11_if bus ();

    census_window_3x11 #(.IMG_ROWS(R), .IMG_COLS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [7:0]  hist[$];
    logic [31:0] seen[int];
    int          vcount    = 0;
    int          acc_cnt   = 0;
    int          corner_at = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'h80;
            1:       return 8'(c % 256);
            default: begin
                if (r == 5 && c == 50)  return 8'd200;
                if (r == 3 && c == 5)   return 8'd200;
                if (r == 8 && c == 100) return 8'd0;
                return 8'd10;
            end
        endcase
    endfunction

    // Neighbour (dr,dc) of the centre sits dr*C+dc positions away in the raster history.
    function automatic logic [31:0] census_ref(input int ci);
        logic [31:0] d = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -5; dc <= 5; dc++) begin
                if (dr != 0 || dc != 0) begin
                    d = {d[30:0], (hist[ci + dr * C + dc] < hist[ci])};
                end
            end
        end
        return d;
    endfunction

    task automatic push(input logic [7:0] p, input int r, input int c, input int fid);
        exp_t e;
        int   n, ci, cr, cc;
        bit   wrapped;
        @(negedge clk);
        bus.en     = 1'b1;
        bus.inData = p;
        bus.row_in = 10'(r);
        bus.col_in = 10'(c);
        hist.push_back(p);
        acc_cnt++;
        n = hist.size() - 1;
        if (n >= WARM) begin
            if (c >= 5) begin cr = r - 1; cc = c - 5;     end
            else        begin cr = r - 2; cc = c + C - 5; end
            wrapped = (cr < 0);
            if (wrapped) cr += R;
            e.row = 10'(cr);
            e.col = 10'(cc);
            e.fid = wrapped ? fid - 1 : fid;
            ci    = n - WARM;
            if (cr == 0 || cr == R - 1 || cc < 5 || cc > C - 6) begin
                e.data = '0; e.known = 1'b1;
            end else if (ci - C - 5 < 0) begin
                e.data = 'x; e.known = 1'b0;
            end else begin
                e.data = census_ref(ci); e.known = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.en = 1'b0;
        end
    endtask

    task automatic send_frame(input int kind, input int fid);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                push(pix_of(kind, r, c), r, c, fid);
                if (fid == 0 && r == 1 && c == 5) check("warmup_no_valid", vcount, 0);
                if (fid == 0 && r == 1 && c == 6) begin
                    check("first_valid", bus.valid, 1);
                    check("first_row", bus.row_out, 0);
                    check("first_col", bus.col_out, 0);
                    check("first_data", bus.outData, 0);
                    check("first_vcount", vcount, 1);
                end
            end
        end
    endtask

    task automatic seen_check(input string tag, input int fid, input int r, input int c,
                              input logic [31:0] exp);
        int key = fid * (1 << 20) + r * 1024 + c;
        check({tag, "_seen"}, seen.exists(key), 1);
        if (seen.exists(key)) check(tag, seen[key], exp);
    endtask

    // Monitor samples 1 time unit after each rising edge.
    logic        en_edge;
    exp_t        mon_e;
    logic [31:0] hold_data;
    logic [9:0]  hold_row, hold_col;
    always @(posedge clk) begin
        en_edge = bus.en && rst_n;
        #1;
        if (!rst_n) begin
            hold_data = '0; hold_row = '0; hold_col = '0;
        end else if (bus.valid) begin
            vcount++;
            check("valid_after_en", en_edge, 1);
            check("sb_occupied", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("row_out", bus.row_out, mon_e.row);
                check("col_out", bus.col_out, mon_e.col);
                if (mon_e.known) check("outData", bus.outData, mon_e.data);
                seen[mon_e.fid * (1 << 20) + int'(mon_e.row) * 1024 + int'(mon_e.col)] = bus.outData;
            end
            if (bus.row_out == 10'(R - 1) && bus.col_out == 10'(C - 1) && corner_at < 0)
                corner_at = acc_cnt;
            hold_data = bus.outData; hold_row = bus.row_out; hold_col = bus.col_out;
        end else begin
            check("hold_data", bus.outData, hold_data);
            check("hold_row", bus.row_out, hold_row);
            check("hold_col", bus.col_out, hold_col);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v1, v2, v3, vr, pos;
        bus.en = 1'b0; bus.inData = '0; bus.row_in = '0; bus.col_in = '0;
        repeat (3) @(negedge clk);
        check("rst_outData", bus.outData, 0);
        check("rst_row_out", bus.row_out, 0);
        check("rst_col_out", bus.col_out, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_test_cnt", bus.test_cnt, 0);
        rst_n = 1'b1;

        // Three back-to-back frames: constant, horizontal ramp, bright/dark spots.
        send_frame(0, 0);
        v1 = vcount;
        send_frame(1, 1);
        v2 = vcount;
        send_frame(2, 2);
        v3 = vcount;
        idle(3);
        check("frame1_valids", v2 - v1, R * C);
        check("frame2_valids", v3 - v2, R * C);
        check("total_valids", vcount, 3 * R * C - WARM);
        check("corner_emit_at", corner_at, R * C + WARM);
        check("test_cnt_frames", bus.test_cnt, 3 * R * C);
        check("sb_drained", sb.size(), 0);

        seen_check("ramp_interior", 1, 5, 100, 32'hF81F07C0);
        seen_check("ramp_col5", 1, 5, 5, 32'hF81F07C0);
        seen_check("border_col4", 1, 5, 4, 32'h0);
        seen_check("border_colmax", 1, 5, C - 5, 32'h0);
        seen_check("border_row0", 1, 0, 100, 32'h0);
        seen_check("border_rowmax", 1, R - 1, 100, 32'h0);
        seen_check("bright_centre", 2, 5, 50, 32'hFFFFFFFF);
        seen_check("bright_col5", 2, 3, 5, 32'hFFFFFFFF);
        seen_check("dark_centre", 2, 8, 100, 32'h0);

        // Sparse stream (one accept every 13 cycles) with a reset mid-row.
        for (int j = 0; j < 200; j++) begin
            push(8'($urandom_range(0, 255)), 0, j, 3);
            idle(12);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        hist.delete();
        #1;
        check("midrst_outData", bus.outData, 0);
        check("midrst_row_out", bus.row_out, 0);
        check("midrst_col_out", bus.col_out, 0);
        check("midrst_valid", bus.valid, 0);
        check("midrst_test_cnt", bus.test_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vr = vcount;
        for (int j = 0; j < 900; j++) begin
            pos = 200 + j;
            push(8'($urandom_range(0, 255)), (pos / C) % R, pos % C, 3);
            idle(12);
            if (j == WARM - 1) check("rst_warmup_no_valid", vcount - vr, 0);
            if (j == WARM)     check("rst_first_valid", vcount - vr, 1);
        end
        idle(3);
        check("rst_total_valids", vcount - vr, 900 - WARM);
        check("rst_test_cnt", bus.test_cnt, 900);
        check("rst_sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
